// File: rtl/mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mix_columns_iter
//  Description : Iterative forward AES MixColumns engine. Accepts a 128-bit
//                state over valid/ready, transforms COLS_PER_CYCLE columns per
//                BUSY cycle in place, then holds the result until taken.
//                A latched bypass flag passes data through with equal latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter step and the bits of the column index that identify a group.
  localparam logic [2:0] c_STEP     = 3'(COLS_PER_CYCLE);
  localparam logic [1:0] c_GRP_MASK = (COLS_PER_CYCLE == 1) ? 2'b11 :
                                      (COLS_PER_CYCLE == 2) ? 2'b10 : 2'b00;

  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column; row 0 is the low byte.
  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] s0, s1, s2, s3;
    logic [7:0] o0, o1, o2, o3;
    s0 = col[7:0];
    s1 = col[15:8];
    s2 = col[23:16];
    s3 = col[31:24];
    o0 = xtime(s0) ^ xtime(s1) ^ s1 ^ s2 ^ s3;
    o1 = s0 ^ xtime(s1) ^ xtime(s2) ^ s2 ^ s3;
    o2 = s0 ^ s1 ^ xtime(s2) ^ xtime(s3) ^ s3;
    o3 = xtime(s0) ^ s0 ^ s1 ^ s2 ^ xtime(s3);
    return {o3, o2, o1, o0};
  endfunction

  state_t         r_state;
  state_t         w_state_next;
  logic [127:0]   r_data;
  logic           r_bypass;
  logic [1:0]     r_cnt;
  logic [127:0]   w_next_data;
  logic [2:0]     w_cnt_sum;
  logic           w_last;
  logic           w_load;
  logic           w_step;

  // Carry out of the 2-bit counter marks the final column group.
  assign w_cnt_sum = {1'b0, r_cnt} + c_STEP;
  assign w_last    = w_cnt_sum[2];

  generate
    for (genvar c = 0; c < 4; c++) begin : g_col
      localparam logic [1:0] c_IDX = 2'(c);
      logic w_sel;
      assign w_sel = ((c_IDX ^ r_cnt) & c_GRP_MASK) == 2'b00;
      assign w_next_data[c*32 +: 32] = (w_sel && !r_bypass) ? mix_col(r_data[c*32 +: 32])
                                                            : r_data[c*32 +: 32];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        w_step = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: load on accept, transform one column group per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= 128'h0;
      r_bypass <= 1'b0;
      r_cnt    <= 2'd0;
    end else if (w_load) begin
      r_data   <= in_data;
      r_bypass <= in_bypass;
      r_cnt    <= 2'd0;
    end else if (w_step) begin
      r_data   <= w_next_data;
      r_cnt    <= w_cnt_sum[1:0];
    end
  end

  assign out_data = r_data;

endmodule
`default_nettype wire

// File: tb/tb_mix_columns_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mix_columns_iter
//  Description : Scoreboard bench for mix_columns_iter, one instance each for
//                COLS_PER_CYCLE = 1, 2, 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_columns_iter;

  typedef struct packed {
    logic [127:0] exp;
    logic [127:0] din;
    logic         byp;
    logic [31:0]  acc;
  } sb_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [2:0]   in_valid = 3'b000;
  logic [2:0]   in_ready;
  logic [127:0] in_data [3];
  logic [2:0]   in_bypass = 3'b000;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [127:0] out_data [3];

  logic [2:0]   rand_en = 3'b000;
  logic [2:0]   man_rdy = 3'b111;
  logic [2:0]   rnd_rdy = 3'b000;

  sb_t          sbq [3][$];
  logic [2:0]   was_valid = 3'b000;
  logic [127:0] hold [3];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    rnd_rdy <= 3'($urandom);
  end

  assign out_ready = (rand_en & rnd_rdy) | (~rand_en & man_rdy);

  generate
    for (genvar g = 0; g < 3; g++) begin : g_dut
      mix_columns_iter #(.COLS_PER_CYCLE((g == 0) ? 1 : (g == 1) ? 2 : 4)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[g]),
        .in_ready  (in_ready[g]),
        .in_data   (in_data[g]),
        .in_bypass (in_bypass[g]),
        .out_valid (out_valid[g]),
        .out_ready (out_ready[g]),
        .out_data  (out_data[g])
      );
    end
  endgenerate

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Reference (inverse when inv=1) MixColumns as a circulant matrix product.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit inv);
    logic [7:0]   fw [4];
    logic [7:0]   iv [4];
    logic [7:0]   o;
    logic [127:0] r;
    fw = '{8'h02, 8'h03, 8'h01, 8'h01};
    iv = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    r  = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) begin
        o = 8'h00;
        for (int j = 0; j < 4; j++) begin
          o = o ^ gmul(inv ? iv[(j - rr + 4) % 4] : fw[(j - rr + 4) % 4], s[c*32 + j*8 +: 8]);
        end
        r[c*32 + rr*8 +: 8] = o;
      end
    end
    return r;
  endfunction

  task automatic chk(input string name, input int k, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%h required=%h", name, k, act, exp);
    end
  endtask

  // Monitor: pop on the first valid cycle of each result, then check it holds.
  always @(negedge clk) begin
    sb_t it;
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        was_valid[k] = 1'b0;
      end else if (out_valid[k]) begin
        if (!was_valid[k]) begin
          if (sbq[k].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output inst=%0d actual=%h required=none", k, out_data[k]);
          end else begin
            it = sbq[k].pop_front();
            chk("data", k, out_data[k], it.exp);
            chk("latency", k, 128'(cyc - int'(it.acc)), 128'(4 >> k));
            if (!it.byp) chk("inverse_roundtrip", k, mix_ref(out_data[k], 1'b1), it.din);
            hold[k] = out_data[k];
          end
        end else begin
          chk("stable", k, out_data[k], hold[k]);
        end
        was_valid[k] = !out_ready[k];
      end
    end
  end

  task automatic send(input int k, input logic [127:0] d, input logic b, input logic [127:0] e);
    int  n;
    bit  ok;
    sb_t it;
    @(posedge clk); #1;
    in_data[k]   = d;
    in_bypass[k] = b;
    in_valid[k]  = 1'b1;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready[k]) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      chk("accept_timeout", k, 128'(0), 128'(1));
      in_valid[k] = 1'b0;
    end else begin
      @(posedge clk); #1;
      it.exp = e;
      it.din = d;
      it.byp = b;
      it.acc = 32'(cyc);
      sbq[k].push_back(it);
      in_valid[k] = 1'b0;
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while (!(sbq[k].size() == 0 && in_ready[k]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("drain_timeout", k, 128'(sbq[k].size()), 128'(0));
  endtask

  task automatic stream(input int k, input int count);
    logic [127:0] d;
    logic         b;
    for (int i = 0; i < count; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      b = ($urandom_range(0, 7) == 0);
      send(k, d, b, b ? d : mix_ref(d, 1'b0));
    end
  endtask

  localparam logic [127:0] c_V1_IN  = {4{32'h455313DB}};
  localparam logic [127:0] c_V1_OUT = {4{32'hBCA14D8E}};
  localparam logic [127:0] c_V2_IN  = {32'hD5D4D4D4, 32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2};
  localparam logic [127:0] c_V2_OUT = {32'hD6D7D5D5, 32'hC6C6C6C6, 32'h01010101, 32'h9D58DC9F};
  localparam logic [127:0] c_V3     = 128'h00112233_44556677_8899AABB_CCDDEEFF;

  initial begin
    int n;
    for (int k = 0; k < 3; k++) in_data[k] = 128'h0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("reset_in_ready", k, 128'(in_ready[k]), 128'(1));
      chk("reset_out_valid", k, 128'(out_valid[k]), 128'(0));
      chk("reset_out_data", k, out_data[k], 128'h0);
    end

    // Directed vectors on each instance.
    send(0, c_V1_IN, 1'b0, c_V1_OUT);
    wait_idle(0);
    send(1, c_V2_IN, 1'b0, c_V2_OUT);
    wait_idle(1);
    send(2, c_V3, 1'b1, c_V3);
    wait_idle(2);

    // Backpressure: result must hold while out_ready is low.
    man_rdy[0] = 1'b0;
    send(0, c_V1_IN, 1'b0, c_V1_OUT);
    n = 0;
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 0, 128'(out_valid[0]), 128'(1));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_data[0]   = {$urandom, $urandom, $urandom, $urandom};
      in_bypass[0] = ~in_bypass[0];
      @(negedge clk);
      chk("bp_in_ready", 0, 128'(in_ready[0]), 128'(0));
      chk("bp_out_valid", 0, 128'(out_valid[0]), 128'(1));
    end
    @(posedge clk); #1;
    man_rdy[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 0, 128'(in_ready[0]), 128'(1));
    chk("bp_release_out_valid", 0, 128'(out_valid[0]), 128'(0));

    // Asynchronous reset two cycles into a P=1 operation.
    send(0, c_V1_IN, 1'b0, c_V1_OUT);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midreset_out_valid", 0, 128'(out_valid[0]), 128'(0));
    chk("midreset_in_ready", 0, 128'(in_ready[0]), 128'(1));
    chk("midreset_out_data", 0, out_data[0], 128'h0);
    sbq[0].delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    send(0, c_V1_IN, 1'b0, c_V1_OUT);
    wait_idle(0);

    // Random streams with random downstream readiness.
    rand_en = 3'b111;
    fork
      stream(0, 100);
      stream(1, 30);
      stream(2, 30);
    join
    for (int k = 0; k < 3; k++) wait_idle(k);
    rand_en = 3'b000;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
